// File: rtl/conj_c_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : conj_c_mult_pipe
//  Purpose  : Per-channel conjugate multiply y[n] = x[n]*conj(x[n-1]), 3-stage
//             pipeline with rounding shift and saturation.
//  Revision : 1.0
// ============================================================================
module conj_c_mult_pipe #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32,
    parameter int NCH       = 1,
    parameter int SHIFT     = 0,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    input  logic [CH_W-1:0]             chan_i,
    input  logic signed [WIDTH-1:0]     real_i,
    input  logic signed [WIDTH-1:0]     imag_i,
    input  logic                        clear_i,
    output logic                        valid_o,
    output logic [CH_W-1:0]             chan_o,
    output logic signed [OUT_WIDTH-1:0] real_o,
    output logic signed [OUT_WIDTH-1:0] imag_o,
    output logic                        sat_o
);

    localparam int PW    = 2 * WIDTH;
    localparam int SW    = 2 * WIDTH + 2;
    localparam int DEPTH = 1 << CH_W;

    localparam logic [CH_W:0]         c_NCH  = (CH_W + 1)'(NCH);
    localparam logic signed [SW-1:0]  c_HALF = (SW'(1) << SHIFT) >> 1;
    localparam logic signed [SW-1:0]  c_MAX  = {{(SW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0]  c_MIN  = {{(SW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [WIDTH-1:0] r_hist_re [DEPTH];
    logic signed [WIDTH-1:0] r_hist_im [DEPTH];
    logic [DEPTH-1:0]        r_primed;

    logic signed [WIDTH-1:0] r_a, r_b, r_c, r_d;
    logic [CH_W-1:0]         r_ch1, r_ch2;
    logic                    r_v1, r_v2;
    logic signed [PW-1:0]    r_ac, r_bd, r_bc, r_ad;

    logic                    w_acc;
    logic                    w_v1;
    logic signed [PW:0]      w_re_s, w_im_s;
    logic [OUT_WIDTH:0]      w_re_q, w_im_q;

    // Round half-up then clamp; MSB of the result flags a clamp.
    function automatic logic [OUT_WIDTH:0] f_scale(input logic signed [PW:0] s);
        logic signed [SW-1:0] t;
        t = {s[PW], s};
        t = (t + c_HALF) >>> SHIFT;
        if (t > c_MAX)
            return {1'b1, c_MAX[OUT_WIDTH-1:0]};
        else if (t < c_MIN)
            return {1'b1, c_MIN[OUT_WIDTH-1:0]};
        return {1'b0, t[OUT_WIDTH-1:0]};
    endfunction

    always_comb begin
        w_acc  = valid_i && ({1'b0, chan_i} < c_NCH);
        // A sample coincident with clear behaves as the first of its channel.
        w_v1   = w_acc && r_primed[chan_i] && !clear_i;
        w_re_s = (PW + 1)'(r_ac) + (PW + 1)'(r_bd);
        w_im_s = (PW + 1)'(r_bc) - (PW + 1)'(r_ad);
        w_re_q = f_scale(w_re_s);
        w_im_q = f_scale(w_im_s);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist_re[i] <= '0;
                r_hist_im[i] <= '0;
            end
            r_primed <= '0;
        end else begin
            if (clear_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_hist_re[i] <= '0;
                    r_hist_im[i] <= '0;
                end
                r_primed <= '0;
            end
            if (w_acc) begin
                r_hist_re[chan_i] <= real_i;
                r_hist_im[chan_i] <= imag_i;
                r_primed[chan_i]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_d   <= '0;
            r_ch1 <= '0;
            r_v1  <= 1'b0;
            r_ac  <= '0;
            r_bd  <= '0;
            r_bc  <= '0;
            r_ad  <= '0;
            r_ch2 <= '0;
            r_v2  <= 1'b0;
        end else begin
            r_a   <= real_i;
            r_b   <= imag_i;
            r_c   <= r_hist_re[chan_i];
            r_d   <= r_hist_im[chan_i];
            r_ch1 <= chan_i;
            r_v1  <= w_v1;
            r_ac  <= PW'(r_a) * PW'(r_c);
            r_bd  <= PW'(r_b) * PW'(r_d);
            r_bc  <= PW'(r_b) * PW'(r_c);
            r_ad  <= PW'(r_a) * PW'(r_d);
            r_ch2 <= r_ch1;
            r_v2  <= r_v1;
        end
    end

    // Result fields hold between results; only valid_o drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            chan_o  <= '0;
            real_o  <= '0;
            imag_o  <= '0;
            sat_o   <= 1'b0;
        end else begin
            valid_o <= r_v2;
            if (r_v2) begin
                chan_o <= r_ch2;
                real_o <= w_re_q[OUT_WIDTH-1:0];
                imag_o <= w_im_q[OUT_WIDTH-1:0];
                sat_o  <= w_re_q[OUT_WIDTH] | w_im_q[OUT_WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conj_c_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conj_c_mult_pipe
//  Purpose  : Directed and randomized self-checking bench for conj_c_mult_pipe.
//  Revision : 1.0
// ============================================================================
module tb_conj_c_mult_pipe;

    typedef struct {
        int     cyc;
        int     ch;
        longint re;
        longint im;
        bit     sat;
    } res_t;

    localparam int SHS[3] = '{0, 1, 4};
    localparam int OWS[3] = '{32, 32, 18};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid_i = 1'b0;
    logic clear_i = 1'b0;
    logic [1:0] chan_i = '0;
    logic signed [15:0] real_i = '0;
    logic signed [15:0] imag_i = '0;

    logic v0, v1, v2, s0, s1, s2;
    logic [1:0] c0, c1, c2;
    logic signed [31:0] r0, i0, r1, i1;
    logic signed [17:0] r2, i2;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    res_t obs[3][$];
    res_t exp_q[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conj_c_mult_pipe #(.WIDTH(16), .OUT_WIDTH(32), .NCH(3), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .chan_i(chan_i), .real_i(real_i),
        .imag_i(imag_i), .clear_i(clear_i), .valid_o(v0), .chan_o(c0),
        .real_o(r0), .imag_o(i0), .sat_o(s0));
    conj_c_mult_pipe #(.WIDTH(16), .OUT_WIDTH(32), .NCH(3), .SHIFT(1)) dut1 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .chan_i(chan_i), .real_i(real_i),
        .imag_i(imag_i), .clear_i(clear_i), .valid_o(v1), .chan_o(c1),
        .real_o(r1), .imag_o(i1), .sat_o(s1));
    conj_c_mult_pipe #(.WIDTH(16), .OUT_WIDTH(18), .NCH(3), .SHIFT(4)) dut2 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .chan_i(chan_i), .real_i(real_i),
        .imag_i(imag_i), .clear_i(clear_i), .valid_o(v2), .chan_o(c2),
        .real_o(r2), .imag_o(i2), .sat_o(s2));

    function automatic res_t mk(input int cy, input int ch, input longint re,
                                input longint im, input bit sat);
        res_t r;
        r.cyc = cy; r.ch = ch; r.re = re; r.im = im; r.sat = sat;
        return r;
    endfunction

    always @(negedge clk) begin
        if (v0) obs[0].push_back(mk(cyc, int'(c0), longint'(r0), longint'(i0), s0));
        if (v1) obs[1].push_back(mk(cyc, int'(c1), longint'(r1), longint'(i1), s1));
        if (v2) obs[2].push_back(mk(cyc, int'(c2), longint'(r2), longint'(i2), s2));
    end

    // Reference: exact complex product, round-half-up division by 2^sh, clamp.
    function automatic res_t model(input int a, input int b, input int c, input int d,
                                   input int sh, input int ow, input int cy, input int ch);
        res_t r;
        longint mx;
        r.re = longint'(a) * longint'(c) + longint'(b) * longint'(d);
        r.im = longint'(b) * longint'(c) - longint'(a) * longint'(d);
        if (sh > 0) begin
            r.re = (r.re + (longint'(1) <<< (sh - 1))) >>> sh;
            r.im = (r.im + (longint'(1) <<< (sh - 1))) >>> sh;
        end
        mx = (longint'(1) <<< (ow - 1)) - 1;
        r.sat = 1'b0;
        if (r.re > mx) begin r.re = mx; r.sat = 1'b1; end
        else if (r.re < -mx - 1) begin r.re = -mx - 1; r.sat = 1'b1; end
        if (r.im > mx) begin r.im = mx; r.sat = 1'b1; end
        else if (r.im < -mx - 1) begin r.im = -mx - 1; r.sat = 1'b1; end
        r.cyc = cy;
        r.ch  = ch;
        return r;
    endfunction

    task automatic flush();
        for (int k = 0; k < 3; k++) begin
            obs[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic drive(input bit v, input int ch, input int a, input int b, input bit clr);
        valid_i = v;
        chan_i  = ch[1:0];
        real_i  = a[15:0];
        imag_i  = b[15:0];
        clear_i = clr;
        @(posedge clk); #1;
        valid_i = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_i = 1'b0; clear_i = 1'b0; chan_i = '0; real_i = '0; imag_i = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        flush();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 0, 1000, -2000, 0);
        drive(1, 0, 300, 700, 0);
        drive(1, 0, -5, 9000, 0);
        drive(1, 0, 123, 456, 0);
        drive(1, 0, 77, 11, 0);
        valid_i = 1'b1; real_i = 16'sd99;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({v0, c0, r0, i0, s0} !== '0 || {v1, r1, i1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b ch=%0d re=%0d im=%0d sat=%0b want all 0",
                     v0, c0, r0, i0, s0);
        end
        @(posedge clk); #1 valid_i = 1'b0;
        @(posedge clk); #1 valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        rst = 1'b1;
        flush();
        idle(5);
        n_tests++;
        if (obs[0].size() + obs[1].size() + obs[2].size() !== 0) begin
            n_fail++;
            $display("FAIL reset_no_valid: got %0d results want 0", obs[0].size());
        end
        drive(1, 0, 5, 5, 0);
        idle(5);
        n_tests++;
        if (obs[0].size() !== 0) begin
            n_fail++;
            $display("FAIL reset_unprimed: got %0d results want 0", obs[0].size());
        end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        drive(1, 0, 3, 4, 0);
        n = cyc;
        drive(1, 0, 1, 2, 0);
        idle(6);
        n_tests++;
        if (obs[0].size() !== 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d want 1", obs[0].size());
        end else begin
            n_tests++;
            if (obs[0][0].cyc !== n + 3 || obs[0][0].re !== 64'sd11 || obs[0][0].im !== 64'sd2 ||
                obs[0][0].sat !== 1'b0 || obs[0][0].ch !== 0) begin
                n_fail++;
                $display("FAIL single_result: got cyc=%0d re=%0d im=%0d sat=%0b want cyc=%0d re=11 im=2 sat=0",
                         obs[0][0].cyc, obs[0][0].re, obs[0][0].im, obs[0][0].sat, n + 3);
            end
        end
        n_tests++;
        if (r0 !== 32'sd11 || i0 !== 32'sd2 || v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold: got v=%0b re=%0d im=%0d want v=0 re=11 im=2", v0, r0, i0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 0, -32768, -32768, 0);
        drive(1, 0, -32768, -32768, 0);
        idle(6);
        n_tests++;
        if (obs[0].size() !== 1 || obs[1].size() !== 1) begin
            n_fail++;
            $display("FAIL sat_count: got %0d/%0d want 1/1", obs[0].size(), obs[1].size());
        end else begin
            n_tests++;
            if (obs[0][0].re !== 64'sd2147483647 || obs[0][0].im !== 64'sd0 || obs[0][0].sat !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_shift0: got re=%0d im=%0d sat=%0b want re=2147483647 im=0 sat=1",
                         obs[0][0].re, obs[0][0].im, obs[0][0].sat);
            end
            n_tests++;
            if (obs[1][0].re !== 64'sd1073741824 || obs[1][0].im !== 64'sd0 || obs[1][0].sat !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_shift1: got re=%0d im=%0d sat=%0b want re=1073741824 im=0 sat=0",
                         obs[1][0].re, obs[1][0].im, obs[1][0].sat);
            end
        end
    endtask

    task automatic test_interleave();
        do_reset();
        drive(1, 0, 100, 0, 0);
        drive(1, 1, 0, 100, 0);
        drive(1, 0, 0, 100, 0);
        drive(1, 1, 100, 0, 0);
        idle(6);
        n_tests++;
        if (obs[0].size() !== 2) begin
            n_fail++;
            $display("FAIL interleave_count: got %0d want 2", obs[0].size());
        end else begin
            n_tests++;
            if (obs[0][0].ch !== 0 || obs[0][0].re !== 64'sd0 || obs[0][0].im !== 64'sd10000) begin
                n_fail++;
                $display("FAIL interleave_ch0: got ch=%0d re=%0d im=%0d want ch=0 re=0 im=10000",
                         obs[0][0].ch, obs[0][0].re, obs[0][0].im);
            end
            n_tests++;
            if (obs[0][1].ch !== 1 || obs[0][1].re !== 64'sd0 || obs[0][1].im !== -64'sd10000 ||
                obs[0][1].cyc !== obs[0][0].cyc + 1) begin
                n_fail++;
                $display("FAIL interleave_ch1: got ch=%0d re=%0d im=%0d want ch=1 re=0 im=-10000",
                         obs[0][1].ch, obs[0][1].re, obs[0][1].im);
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        drive(1, 0, 5, 5, 0);
        drive(1, 0, 3, 0, 0);
        drive(1, 0, 7, 0, 1);
        drive(1, 0, 7, 0, 0);
        idle(6);
        n_tests++;
        if (obs[0].size() !== 2) begin
            n_fail++;
            $display("FAIL clear_count: got %0d want 2", obs[0].size());
        end else begin
            n_tests++;
            if (obs[0][0].re !== 64'sd15 || obs[0][0].im !== -64'sd15) begin
                n_fail++;
                $display("FAIL clear_inflight: got re=%0d im=%0d want re=15 im=-15",
                         obs[0][0].re, obs[0][0].im);
            end
            n_tests++;
            if (obs[0][1].re !== 64'sd49 || obs[0][1].im !== 64'sd0 || obs[0][1].sat !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_after: got re=%0d im=%0d want re=49 im=0",
                         obs[0][1].re, obs[0][1].im);
            end
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        drive(1, 0, 2, 3, 0);
        drive(1, 3, 99, 99, 0);
        drive(1, 0, 4, 1, 0);
        idle(6);
        n_tests++;
        if (obs[0].size() !== 1) begin
            n_fail++;
            $display("FAIL oor_count: got %0d want 1", obs[0].size());
        end else begin
            n_tests++;
            if (obs[0][0].ch !== 0 || obs[0][0].re !== 64'sd11 || obs[0][0].im !== -64'sd10) begin
                n_fail++;
                $display("FAIL oor_result: got ch=%0d re=%0d im=%0d want ch=0 re=11 im=-10",
                         obs[0][0].ch, obs[0][0].re, obs[0][0].im);
            end
        end
    endtask

    task automatic test_random();
        int a, b, ch, n, sel;
        bit v, clr;
        int hre[3], him[3];
        bit pr[3];
        do_reset();
        for (int i = 0; i < 3; i++) begin hre[i] = 0; him[i] = 0; pr[i] = 1'b0; end
        for (int t = 0; t < 500; t++) begin
            v   = ($urandom_range(0, 3) != 0);
            ch  = int'($urandom_range(0, 3));
            clr = ($urandom_range(0, 39) == 0);
            sel = int'($urandom_range(0, 5));
            a   = (sel == 0) ? -32768 : (sel == 1) ? 32767 : int'($urandom_range(0, 65535)) - 32768;
            sel = int'($urandom_range(0, 5));
            b   = (sel == 0) ? -32768 : (sel == 1) ? 32767 : int'($urandom_range(0, 65535)) - 32768;
            n   = cyc;
            if (clr)
                for (int i = 0; i < 3; i++) begin hre[i] = 0; him[i] = 0; pr[i] = 1'b0; end
            if (v && ch < 3) begin
                if (pr[ch])
                    for (int k = 0; k < 3; k++)
                        exp_q[k].push_back(model(a, b, hre[ch], him[ch], SHS[k], OWS[k], n + 3, ch));
                hre[ch] = a;
                him[ch] = b;
                pr[ch]  = 1'b1;
            end
            drive(v, ch, a, b, clr);
        end
        idle(6);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs[k].size() !== exp_q[k].size()) begin
                n_fail++;
                $display("FAIL random_count[%0d]: got %0d want %0d", k, obs[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < obs[k].size() && i < exp_q[k].size(); i++) begin
                n_tests++;
                if (obs[k][i] != exp_q[k][i]) begin
                    n_fail++;
                    $display("FAIL random[%0d][%0d]: got cyc=%0d ch=%0d re=%0d im=%0d sat=%0b want cyc=%0d ch=%0d re=%0d im=%0d sat=%0b",
                             k, i, obs[k][i].cyc, obs[k][i].ch, obs[k][i].re, obs[k][i].im, obs[k][i].sat,
                             exp_q[k][i].cyc, exp_q[k][i].ch, exp_q[k][i].re, exp_q[k][i].im, exp_q[k][i].sat);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_interleave();
        test_clear();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conj_c_mult_pipe.md
Name: conj_c_mult_pipe

Overview:
- Parametrised, pipelined successor of the FM discriminator's conjugate-multiply stage.
- Computes the full complex product y[n] = x[n]·conj(x[n-1]), both real and imaginary parts, for up to NCH time-multiplexed channels. Each channel keeps its own sample history.
- Sits between the IQ merge stage and the phase/angle stage.
- Adds valid handshake, per-channel priming, history clear, rounding shift and saturation to OUT_WIDTH.

Parameters:
- WIDTH, 16: signed width of the real_i/imag_i input samples.
- OUT_WIDTH, 32: signed width of real_o/imag_o, range 2..2*WIDTH+1.
- NCH, 1: number of interleaved channels, range 1..16.
- SHIFT, 0: arithmetic right shift with rounding, applied before saturation, range 0..2*WIDTH.
- CH_W, derived as max(1, clog2(NCH)): channel index width. This is a localparam, not user-settable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  input sample valid.
- chan_i  in  CH_W  channel index of the input sample.
- real_i  in  WIDTH  signed in-phase sample (a).
- imag_i  in  WIDTH  signed quadrature sample (b).
- clear_i  in  1  synchronous clear of all channel histories.
- valid_o  out  1  output valid, one cycle per result.
- chan_o  out  CH_W  channel index of the result.
- real_o  out  OUT_WIDTH  Re{y} = a·c + b·d.
- imag_o  out  OUT_WIDTH  Im{y} = b·c − a·d.
- sat_o  out  1  real_o or imag_o saturated for this result.

Behaviour:
- Reset (rst=0, asynchronous):
  - All pipeline registers cleared; valid_o=0, chan_o=0, real_o=0, imag_o=0, sat_o=0.
  - All history entries (c,d) and all primed flags cleared.
  - Reset mid-operation discards in-flight results; no valid_o until new input arrives.
- Per-channel state: hist_re[ch], hist_im[ch] (WIDTH each) and primed[ch].
- S0, accept (valid_i=1 and chan_i<NCH):
  - Read the previous sample (c,d) of that channel combinationally.
  - Write the new sample (a,b) into the history at the clock edge.
  - Set primed[chan_i].
- Stage 1 register: a, b, c, d, chan, and v1 = valid_i & primed[chan_i] (primed value before update).
- Stage 2 register: the four products a·c, b·d, b·c, a·d, each 2*WIDTH signed. v2 = v1.
- Stage 3 register:
  - Sums are 2*WIDTH+1 bits.
  - If SHIFT>0, add 2^(SHIFT-1), then arithmetic shift right by SHIFT.
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - sat_o = OR of both saturation events. valid_o = v2.
- Latency: exactly 3 clk from the valid_i edge to valid_o. Throughput is one sample per clk.
- Streaming is unconditional (no ready). Any mix of channels is allowed back-to-back, including the same channel on consecutive cycles: the history write at edge k is seen by the read at edge k+1.
- First sample of a channel after reset or clear: history written, no valid_o generated.
- Non-result cycles: outputs hold their last values; only valid_o deasserts. sat_o is meaningful only with valid_o.
- clear_i=1:
  - All primed flags and histories are zeroed at the edge.
  - If valid_i is coincident, that sample is then stored as the new history, primed is set, and no output is produced (it acts as a first sample).
  - Results already in flight still emerge.
- valid_i with chan_i≥NCH: sample ignored. No history change and no output.
- valid_i=0: histories unchanged, bubble propagates.
- Arithmetic is two's complement throughout. No conjugate negation of d is stored; the −d is applied in the sum equations.

Test Plan:
- Reset: assert rst=0 mid-stream with valid_i toggling -> all outputs 0 immediately; valid_o stays 0 for ≥3 clk after release with no input.
- Single channel (NCH=1, SHIFT=0, OUT_WIDTH=32): inputs (3,4) then (1,2) -> exactly one valid_o, 3 clk after the second input, with real_o=11, imag_o=2, sat_o=0.
- Saturation: inputs (−32768,−32768) twice -> real_o=2147483647, sat_o=1, imag_o=0. Repeat with SHIFT=1 -> real_o=1073741824, sat_o=0.
- Interleave (NCH=4): ch0(100,0), ch1(0,100), ch0(0,100), ch1(100,0) on consecutive clk -> two results. ch0: real 0, imag 10000. ch1: real 0, imag −10000. chan_o correct.
- Clear: ch0(5,5), then clear_i with ch0(7,0), then ch0(7,0) -> single result from the last pair only: real_o=49, imag_o=0.
- Out-of-range channel (NCH=3): chan_i=3 with data between two ch0 samples -> no output for it, and the ch0 result is unaffected.
